// File: rtl/spi_commit_scheduler.sv
// Defers SPI vector/register updates and commits them one per cycle during vertical blanking.
// Holds a single overwrite-on-arrival vector slot and a small FIFO of register writes.
module spi_commit_scheduler #(
    parameter int VEC_W    = 60,
    parameter int REG_AW   = 4,
    parameter int REG_DW   = 16,
    parameter int FIFO_D   = 4,
    parameter int V_ACTIVE = 480
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [9:0]                i_hpos,
    input  logic [9:0]                i_vpos,
    input  logic                      i_hold,
    input  logic                      i_vec_valid,
    input  logic [VEC_W-1:0]          i_vec_data,
    input  logic                      i_reg_valid,
    input  logic [REG_AW-1:0]         i_reg_addr,
    input  logic [REG_DW-1:0]         i_reg_data,
    output logic                      o_vec_we,
    output logic [VEC_W-1:0]          o_vec_q,
    output logic                      o_reg_we,
    output logic [REG_AW-1:0]         o_reg_waddr,
    output logic [REG_DW-1:0]         o_reg_wdata,
    output logic                      o_frame_done,
    output logic                      o_vec_pending,
    output logic [$clog2(FIFO_D):0]   o_reg_count,
    output logic                      o_reg_ovf
);

    localparam int PW = $clog2(FIFO_D);
    localparam int CW = PW + 1;
    localparam int EW = REG_AW + REG_DW;

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic [VEC_W-1:0]  vec_slot;
    logic [EW-1:0]     fifo_mem [FIFO_D];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic              in_win, fifo_empty, fifo_full;
    logic              commit_vec, commit_reg, frame_done_nxt;
    logic              push, ovf_set;

    assign in_win     = (i_vpos >= 10'(V_ACTIVE));
    assign fifo_empty = (o_reg_count == '0);
    assign fifo_full  = (o_reg_count == CW'(FIFO_D));

    // A strobe arriving on the edge that would finish the drain keeps us in DRAIN,
    // so a freshly captured item commits on the very next edge.
    always_comb begin
        state_nxt      = state;
        commit_vec     = 1'b0;
        commit_reg     = 1'b0;
        frame_done_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (in_win) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!in_win) begin
                    state_nxt = IDLE;
                end else if (!i_hold) begin
                    if (o_vec_pending) begin
                        commit_vec = 1'b1;
                    end else if (!fifo_empty) begin
                        commit_reg = 1'b1;
                    end else if (!i_vec_valid && !i_reg_valid) begin
                        state_nxt      = DONE;
                        frame_done_nxt = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!in_win) begin
                    state_nxt = IDLE;
                end else if (o_vec_pending || !fifo_empty) begin
                    state_nxt = DRAIN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A push into a full FIFO only survives when the head is popped on the same edge.
    assign push    = i_reg_valid && (!fifo_full || commit_reg);
    assign ovf_set = i_reg_valid && fifo_full && !commit_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            o_vec_we      <= 1'b0;
            o_reg_we      <= 1'b0;
            o_frame_done  <= 1'b0;
            o_vec_q       <= '0;
            o_reg_waddr   <= '0;
            o_reg_wdata   <= '0;
            vec_slot      <= '0;
            o_vec_pending <= 1'b0;
            o_reg_count   <= '0;
            o_reg_ovf     <= 1'b0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
        end else begin
            state        <= state_nxt;
            o_vec_we     <= commit_vec;
            o_reg_we     <= commit_reg;
            o_frame_done <= frame_done_nxt;
            if (commit_vec) o_vec_q <= vec_slot;
            if (commit_reg) {o_reg_waddr, o_reg_wdata} <= fifo_mem[rd_ptr];
            if (i_vec_valid) begin
                vec_slot      <= i_vec_data;
                o_vec_pending <= 1'b1;
            end else if (commit_vec) begin
                o_vec_pending <= 1'b0;
            end
            if (push)       wr_ptr <= wr_ptr + 1'b1;
            if (commit_reg) rd_ptr <= rd_ptr + 1'b1;
            if (push && !commit_reg)      o_reg_count <= o_reg_count + 1'b1;
            else if (!push && commit_reg) o_reg_count <= o_reg_count - 1'b1;
            if (ovf_set) o_reg_ovf <= 1'b1;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {i_reg_addr, i_reg_data};
    end

endmodule

// File: tb/tb_spi_commit_scheduler.sv
// Directed self-checking bench for spi_commit_scheduler: deferral, priority, overflow,
// window close with hold, and asynchronous reset mid-drain.
module tb_spi_commit_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  i_hpos, i_vpos;
    logic        i_hold, i_vec_valid, i_reg_valid;
    logic [59:0] i_vec_data;
    logic [3:0]  i_reg_addr;
    logic [15:0] i_reg_data;
    logic        o_vec_we, o_reg_we, o_frame_done, o_vec_pending, o_reg_ovf;
    logic [59:0] o_vec_q;
    logic [3:0]  o_reg_waddr;
    logic [15:0] o_reg_wdata;
    logic [2:0]  o_reg_count;

    int numChecks = 0;
    int numFails  = 0;

    spi_commit_scheduler dut (
        .clk(clk), .reset(reset), .i_hpos(i_hpos), .i_vpos(i_vpos), .i_hold(i_hold),
        .i_vec_valid(i_vec_valid), .i_vec_data(i_vec_data),
        .i_reg_valid(i_reg_valid), .i_reg_addr(i_reg_addr), .i_reg_data(i_reg_data),
        .o_vec_we(o_vec_we), .o_vec_q(o_vec_q), .o_reg_we(o_reg_we),
        .o_reg_waddr(o_reg_waddr), .o_reg_wdata(o_reg_wdata), .o_frame_done(o_frame_done),
        .o_vec_pending(o_vec_pending), .o_reg_count(o_reg_count), .o_reg_ovf(o_reg_ovf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        numChecks++;
        if (observed !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one strobe cycle (vector and/or register) across a single edge, then idles the inputs.
    task automatic applyStimulus(input logic vv, input logic [59:0] vd,
                                 input logic rv, input logic [3:0] ra, input logic [15:0] rd);
        i_vec_valid = vv;
        i_vec_data  = vd;
        i_reg_valid = rv;
        i_reg_addr  = ra;
        i_reg_data  = rd;
        tick();
        i_vec_valid = 1'b0;
        i_reg_valid = 1'b0;
    endtask

    task automatic expectReg(input string tag, input logic [3:0] addr, input logic [15:0] data);
        checkOutput({tag, "_we"}, 64'(o_reg_we), 64'd1);
        checkOutput({tag, "_vwe"}, 64'(o_vec_we), 64'd0);
        checkOutput({tag, "_addr"}, 64'(o_reg_waddr), 64'(addr));
        checkOutput({tag, "_data"}, 64'(o_reg_wdata), 64'(data));
    endtask

    initial begin
        reset = 1'b1;
        i_hpos = '0; i_vpos = '0; i_hold = 1'b0;
        i_vec_valid = 1'b0; i_vec_data = '0;
        i_reg_valid = 1'b0; i_reg_addr = '0; i_reg_data = '0;
        #3;
        checkOutput("rst_vec_we", 64'(o_vec_we), 64'd0);
        checkOutput("rst_reg_we", 64'(o_reg_we), 64'd0);
        checkOutput("rst_done", 64'(o_frame_done), 64'd0);
        checkOutput("rst_vec_q", 64'(o_vec_q), 64'd0);
        checkOutput("rst_waddr", 64'(o_reg_waddr), 64'd0);
        checkOutput("rst_wdata", 64'(o_reg_wdata), 64'd0);
        checkOutput("rst_pend", 64'(o_vec_pending), 64'd0);
        checkOutput("rst_count", 64'(o_reg_count), 64'd0);
        checkOutput("rst_ovf", 64'(o_reg_ovf), 64'd0);
        tick();
        reset = 1'b0;
        tick();

        // Vector deferral
        i_vpos = 10'd100;
        applyStimulus(1'b1, 60'h123456789ABCDEF, 1'b0, 4'd0, 16'd0);
        checkOutput("defer_pend", 64'(o_vec_pending), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("defer_no_we", 64'(o_vec_we), 64'd0);
        end
        i_vpos = 10'd480;
        tick();
        checkOutput("defer_entry_we", 64'(o_vec_we), 64'd0);
        tick();
        checkOutput("defer_we", 64'(o_vec_we), 64'd1);
        checkOutput("defer_q", 64'(o_vec_q), 64'h123456789ABCDEF);
        checkOutput("defer_pend_clr", 64'(o_vec_pending), 64'd0);
        tick();
        checkOutput("defer_we_drop", 64'(o_vec_we), 64'd0);
        checkOutput("defer_done", 64'(o_frame_done), 64'd1);
        checkOutput("defer_q_hold", 64'(o_vec_q), 64'h123456789ABCDEF);
        tick();
        checkOutput("defer_done_pulse", 64'(o_frame_done), 64'd0);
        i_vpos = 10'd0;
        tick();

        // Vector overwrite
        applyStimulus(1'b1, 60'hAAAA, 1'b0, 4'd0, 16'd0);
        applyStimulus(1'b1, 60'hBBBB, 1'b0, 4'd0, 16'd0);
        i_vpos = 10'd480;
        tick();
        tick();
        checkOutput("ovw_we", 64'(o_vec_we), 64'd1);
        checkOutput("ovw_q", 64'(o_vec_q), 64'hBBBB);
        tick();
        checkOutput("ovw_single", 64'(o_vec_we), 64'd0);
        checkOutput("ovw_done", 64'(o_frame_done), 64'd1);
        checkOutput("ovw_ovf", 64'(o_reg_ovf), 64'd0);
        i_vpos = 10'd0;
        tick();

        // Priority and order
        applyStimulus(1'b0, 60'd0, 1'b1, 4'd1, 16'h0011);
        applyStimulus(1'b0, 60'd0, 1'b1, 4'd2, 16'h0022);
        applyStimulus(1'b1, 60'hC0FFEE, 1'b0, 4'd0, 16'd0);
        checkOutput("prio_count", 64'(o_reg_count), 64'd2);
        i_vpos = 10'd480;
        tick();
        checkOutput("prio_entry", 64'(o_vec_we | o_reg_we), 64'd0);
        tick();
        checkOutput("prio_vwe", 64'(o_vec_we), 64'd1);
        checkOutput("prio_vq", 64'(o_vec_q), 64'hC0FFEE);
        checkOutput("prio_vrwe", 64'(o_reg_we), 64'd0);
        tick();
        expectReg("prio_r1", 4'd1, 16'h0011);
        tick();
        expectReg("prio_r2", 4'd2, 16'h0022);
        checkOutput("prio_empty", 64'(o_reg_count), 64'd0);
        tick();
        checkOutput("prio_done", 64'(o_frame_done), 64'd1);
        checkOutput("prio_rwe_drop", 64'(o_reg_we), 64'd0);
        i_vpos = 10'd0;
        tick();

        // Overflow
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 60'd0, 1'b1, 4'(3 + i), 16'(16'h0100 + i));
        checkOutput("ovf_count4", 64'(o_reg_count), 64'd4);
        checkOutput("ovf_not_yet", 64'(o_reg_ovf), 64'd0);
        applyStimulus(1'b0, 60'd0, 1'b1, 4'd7, 16'h0777);
        checkOutput("ovf_count_full", 64'(o_reg_count), 64'd4);
        checkOutput("ovf_flag", 64'(o_reg_ovf), 64'd1);
        i_vpos = 10'd480;
        tick();
        applyStimulus(1'b0, 60'd0, 1'b1, 4'd8, 16'h0888);
        expectReg("ovf_r3", 4'd3, 16'h0100);
        checkOutput("ovf_pushpop_count", 64'(o_reg_count), 64'd4);
        checkOutput("ovf_pushpop_flag", 64'(o_reg_ovf), 64'd1);
        tick();
        expectReg("ovf_r4", 4'd4, 16'h0101);
        tick();
        expectReg("ovf_r5", 4'd5, 16'h0102);
        tick();
        expectReg("ovf_r6", 4'd6, 16'h0103);
        tick();
        expectReg("ovf_r8", 4'd8, 16'h0888);
        tick();
        checkOutput("ovf_done", 64'(o_frame_done), 64'd1);
        checkOutput("ovf_no_extra", 64'(o_reg_we), 64'd0);
        i_vpos = 10'd0;
        tick();

        // Window close while held
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 60'd0, 1'b1, 4'(9 + i), 16'(16'h0A09 + i));
        i_hold = 1'b1;
        i_vpos = 10'd480;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("hold_no_we", 64'(o_reg_we | o_vec_we), 64'd0);
            checkOutput("hold_no_done", 64'(o_frame_done), 64'd0);
            checkOutput("hold_count", 64'(o_reg_count), 64'd3);
        end
        i_vpos = 10'd0;
        tick();
        i_hold = 1'b0;
        tick();
        checkOutput("close_no_we", 64'(o_reg_we), 64'd0);
        checkOutput("close_count", 64'(o_reg_count), 64'd3);
        i_vpos = 10'd480;
        tick();
        checkOutput("reopen_entry", 64'(o_reg_we), 64'd0);
        tick();
        expectReg("reopen_r9", 4'd9, 16'h0A09);
        tick();
        expectReg("reopen_r10", 4'd10, 16'h0A0A);
        tick();
        expectReg("reopen_r11", 4'd11, 16'h0A0B);
        tick();
        checkOutput("reopen_done", 64'(o_frame_done), 64'd1);
        i_vpos = 10'd0;
        tick();

        // Asynchronous reset mid-drain
        applyStimulus(1'b0, 60'd0, 1'b1, 4'd1, 16'h1111);
        applyStimulus(1'b0, 60'd0, 1'b1, 4'd2, 16'h2222);
        applyStimulus(1'b1, 60'hDEAD, 1'b0, 4'd0, 16'd0);
        i_vpos = 10'd480;
        tick();
        tick();
        checkOutput("mid_vwe", 64'(o_vec_we), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("arst_vwe", 64'(o_vec_we), 64'd0);
        checkOutput("arst_rwe", 64'(o_reg_we), 64'd0);
        checkOutput("arst_count", 64'(o_reg_count), 64'd0);
        checkOutput("arst_ovf", 64'(o_reg_ovf), 64'd0);
        checkOutput("arst_pend", 64'(o_vec_pending), 64'd0);
        #2;
        reset = 1'b0;
        applyStimulus(1'b1, 60'hBEEF, 1'b0, 4'd0, 16'd0);
        checkOutput("post_idle_no_we", 64'(o_vec_we), 64'd0);
        tick();
        checkOutput("post_lat_we", 64'(o_vec_we), 64'd1);
        checkOutput("post_lat_q", 64'(o_vec_q), 64'hBEEF);
        checkOutput("post_no_reg", 64'(o_reg_we), 64'd0);
        tick();
        checkOutput("post_done", 64'(o_frame_done), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule

// File: doc/spi_commit_scheduler.md
# spi_commit_scheduler

Defers and serialises register updates arriving from the two SPI peripheral interfaces (vector SPI and register SPI) so that they reach the renderer's live registers only during vertical blanking. This avoids mid-frame tearing. The block sits between the SPI deserialisers and the rbzero register file and is driven by the VGA timing counters (hpos/vpos). It holds one pending vector update and a small FIFO of register writes, then drains them one commit per cycle while the blanking window is open.

## Interface
- VEC_W, 60: vector payload width (player X/Y, facing X/Y, plane X/Y).
- REG_AW, 4: register address width.
- REG_DW, 16: register data width.
- FIFO_D, 4: register-write FIFO depth; must be a power of two, at least 2.
- V_ACTIVE, 480: first vpos line of the commit window. The window is open while vpos >= V_ACTIVE.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- i_hpos  in  10  current horizontal position. Used only in the test plan; no logic depends on it.
- i_vpos  in  10  current vertical position.
- i_hold  in  1  when high, no commits are issued. Captures still proceed.
- i_vec_valid  in  1  one-cycle strobe; i_vec_data holds a complete vector update.
- i_vec_data  in  VEC_W  vector payload.
- i_reg_valid  in  1  one-cycle strobe; a complete register write is present.
- i_reg_addr  in  REG_AW  register address.
- i_reg_data  in  REG_DW  register data.
- o_vec_we  out  1  vector commit strobe, one cycle.
- o_vec_q  out  VEC_W  committed vector. Valid while o_vec_we is high; holds its value otherwise.
- o_reg_we  out  1  register commit strobe, one cycle.
- o_reg_waddr  out  REG_AW  committed register address.
- o_reg_wdata  out  REG_DW  committed register data.
- o_frame_done  out  1  one-cycle pulse when the window's backlog is fully drained.
- o_vec_pending  out  1  the vector slot is occupied.
- o_reg_count  out  $clog2(FIFO_D)+1  number of FIFO entries.
- o_reg_ovf  out  1  sticky overflow flag; cleared only by reset.

## Operation
- in_win = (i_vpos >= V_ACTIVE). It is computed combinationally, unsigned, over 10 bits.
- **Vector slot, single entry.**
  - i_vec_valid loads the slot and sets pending.
  - If the slot is already full, the newer value overwrites it. This is not an overflow.
- **Register FIFO.**
  - i_reg_valid pushes {addr, data}.
  - A push when full with no pop in the same cycle is dropped and sets o_reg_ovf.
  - A push and pop in the same cycle are both performed; count is unchanged. This includes the full case, which is then not an overflow.
  - Read and write pointers wrap modulo FIFO_D.
- **FSM states: IDLE, DRAIN, DONE.**
  - IDLE, entered on reset: no commits. If in_win, go to DRAIN.
  - DRAIN: commits are issued under the rules below.
    - If !in_win, go to IDLE; leftover items wait for the next frame.
    - If nothing is pending and i_hold is low, go to DONE and register o_frame_done=1 for one cycle.
  - DONE: no commits.
    - If !in_win, go to IDLE.
    - If an item becomes pending, go to DRAIN.
- **Commit rule, evaluated on each edge in DRAIN with i_hold low. At most one commit per edge.**
  - If the vector slot is pending, the edge registers o_vec_we=1 and o_vec_q=slot, and clears pending.
  - Otherwise, if the FIFO is non-empty, the edge pops the head and registers o_reg_we=1 with its address and data.
  - o_vec_we and o_reg_we are never high together.
- **Capture vs commit in the same edge.**
  - If i_vec_valid coincides with a vector commit, the old slot value is committed and the new value remains pending.
- FIFO order is preserved. Vector priority does not reorder register writes among themselves.

## Timing
- **Reset values:** state=IDLE; all outputs 0; o_vec_q, o_reg_waddr and o_reg_wdata are 0; FIFO empty; slot empty.
- **Outputs:** all outputs are registered.
  - o_vec_pending and o_reg_count reflect the state after the most recent edge.
- **Latency:**
  - A strobe sampled at edge N, while in DRAIN with an empty backlog, produces its commit strobe high after edge N+1.
- **Window entry:**
  - The first edge with in_win moves the FSM from IDLE to DRAIN; no commit occurs on that edge.
  - The first commit occurs on edge +1 from that.
- **Drain time:**
  - A backlog of k items takes k cycles.
  - o_frame_done is registered on the edge after the last commit.
- **i_hold:** stretches the drain. The FSM stays in DRAIN and o_frame_done is not asserted while held.
- **Asynchronous reset mid-drain:** pending data is discarded and strobes drop immediately.

## Test plan
- **Reset mid-drain:** assert reset during a drain -> all strobes 0 asynchronously; count 0; ovf 0; state IDLE after release.
- **Vector deferral:**
  - Stimulus: vpos=100, pulse i_vec_valid with data 0x123456789ABCDEF.
  - Required: no o_vec_we while vpos<480.
  - When vpos reaches 480: exactly one o_vec_we with that data on the second edge; o_frame_done on the next edge.
- **Vector overwrite:**
  - Stimulus: outside the window, two vector strobes, A then B.
  - Required: in the window, a single commit of B; o_reg_ovf stays 0.
- **Priority and order:**
  - Stimulus: outside the window, push reg (1,0x0011), (2,0x0022), then a vector V.
  - Required: in the window, commits appear as V, (1,0x0011), (2,0x0022) on consecutive cycles, then o_frame_done.
- **Overflow:**
  - Stimulus: outside the window, push 5 register writes with FIFO_D=4.
  - Required: o_reg_count=4, o_reg_ovf=1, and only the first 4 are committed.
  - In the window, a push in the same cycle as a pop while full -> no overflow change, count stays 4.
- **Window close:**
  - Stimulus: 3 items pending, i_hold high until vpos returns to 0.
  - Required: no commits, no o_frame_done, state IDLE, o_reg_count unchanged.
  - On the next window, all 3 items drain in order.
